// File: rtl/hist_update_ctrl.sv
// Histogram bin update controller: read-modify-write of one RAM bin per sample, plus a full clear sweep.
// Define HIST_SATURATE_EN to make bins saturate at all-ones and raise sat_flag; by default bins wrap.
module hist_update_ctrl #(
    parameter int BIN_AW = 6,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [BIN_AW-1:0] in_bin,
    output logic              in_ready,
    input  logic              clear_req,
    output logic              clear_done,
    output logic              busy,
    output logic [CNT_W-1:0]  sample_count,
    output logic              sat_flag,
    output logic [BIN_AW-1:0] ram_address,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic [3:0]        ram_byteenable,
    output logic [CNT_W-1:0]  ram_writedata,
    input  logic [CNT_W-1:0]  ram_readdata
);

    // state | meaning
    // IDLE  | accept a sample (read issued) or start a pending clear
    // UPD   | write readdata+1 back to the registered bin
    // CLR   | zero one address per cycle, 0 .. 2^BIN_AW-1
    typedef enum logic [1:0] {IDLE, UPD, CLR} state_t;

    localparam logic [CNT_W-1:0]  CNT_ONE  = 1;
    localparam logic [BIN_AW-1:0] ADDR_ONE = 1;

    state_t            state, state_nxt;
    logic [BIN_AW-1:0] bin_q;
    logic [BIN_AW-1:0] clr_addr;
    logic              clr_pending;
    logic              done_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  upd_data;
    logic              clear_go;
    logic              accept;
    logic              last_addr;

    assign clear_go  = (state == IDLE) && (clear_req || clr_pending);
    assign accept    = in_valid && in_ready;
    assign last_addr = (clr_addr == '1);

`ifdef HIST_SATURATE_EN
    logic sat_q;
    logic at_max;

    assign at_max   = &ram_readdata;
    assign upd_data = at_max ? ram_readdata : ram_readdata + CNT_ONE;
    assign sat_flag = ~reset & (sat_q | ((state == UPD) & at_max));

    always_ff @(posedge clk) begin
        if (reset)
            sat_q <= 1'b0;
        else if (clear_go)
            sat_q <= 1'b0;
        else if (state == UPD && at_max)
            sat_q <= 1'b1;
    end
`else
    assign upd_data = ram_readdata + CNT_ONE;
    assign sat_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            bin_q       <= '0;
            clr_addr    <= '0;
            clr_pending <= 1'b0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state  <= state_nxt;
            done_q <= (state == CLR) && last_addr;
            if (accept)
                bin_q <= in_bin;
            if (clear_go) begin
                clr_pending <= 1'b0;
                cnt_q       <= '0;
                clr_addr    <= '0;
            end else begin
                // a request arriving mid-operation is remembered, never restarts a sweep
                if (clear_req)
                    clr_pending <= 1'b1;
                if (state == UPD)
                    cnt_q <= cnt_q + CNT_ONE;
                if (state == CLR)
                    clr_addr <= clr_addr + ADDR_ONE;
            end
        end
    end

    always_comb begin
        state_nxt      = state;
        in_ready       = 1'b0;
        ram_address    = '0;
        ram_chipselect = 1'b0;
        ram_write      = 1'b0;
        ram_byteenable = 4'h0;
        ram_writedata  = '0;
        case (state)
            IDLE: begin
                in_ready = ~clear_go;
                if (clear_go) begin
                    state_nxt = CLR;
                end else if (in_valid) begin
                    state_nxt      = UPD;
                    ram_address    = in_bin;
                    ram_chipselect = 1'b1;
                    ram_byteenable = 4'hF;
                end
            end
            UPD: begin
                ram_address    = bin_q;
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_byteenable = 4'hF;
                ram_writedata  = upd_data;
                state_nxt      = IDLE;
            end
            CLR: begin
                ram_address    = clr_addr;
                ram_chipselect = 1'b1;
                ram_write      = 1'b1;
                ram_byteenable = 4'hF;
                if (last_addr)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // reset is synchronous, so outputs are masked combinationally while it is held
        if (reset) begin
            in_ready       = 1'b0;
            ram_chipselect = 1'b0;
            ram_write      = 1'b0;
        end
    end

    assign busy         = (state != IDLE) && !reset;
    assign clear_done   = done_q && !reset;
    assign sample_count = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_hist_update_ctrl.sv
// Self-checking bench for hist_update_ctrl: RAM model, bin-count reference model, directed and random steps.
// Expectations follow HIST_SATURATE_EN when the bundle is built with it.
module tb_hist_update_ctrl;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [5:0]  in_bin;
    logic        in_ready;
    logic        clear_req;
    logic        clear_done;
    logic        busy;
    logic [31:0] sample_count;
    logic        sat_flag;
    logic [5:0]  ram_address;
    logic        ram_chipselect;
    logic        ram_write;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;
    logic [31:0] ram_readdata;

    hist_update_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_bin         (in_bin),
        .in_ready       (in_ready),
        .clear_req      (clear_req),
        .clear_done     (clear_done),
        .busy           (busy),
        .sample_count   (sample_count),
        .sat_flag       (sat_flag),
        .ram_address    (ram_address),
        .ram_chipselect (ram_chipselect),
        .ram_write      (ram_write),
        .ram_byteenable (ram_byteenable),
        .ram_writedata  (ram_writedata),
        .ram_readdata   (ram_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM: address registered on a read, data returned combinationally
    typedef struct {
        int          cyc;
        int          addr;
        logic [31:0] data;
    } wr_t;

    logic [31:0] mem [64];
    logic [5:0]  addr_q = '0;
    wr_t         wlog [$];
    int          cyc = 0;
    int          be_errs = 0;

    assign ram_readdata = mem[addr_q];

    always @(posedge clk) begin
        if (ram_chipselect && ram_write) begin
            mem[ram_address] <= ram_writedata;
            wlog.push_back('{cyc, int'(ram_address), ram_writedata});
            if (ram_byteenable != 4'hF) be_errs++;
        end else if (ram_chipselect) begin
            addr_q <= ram_address;
        end
        cyc <= cyc + 1;
    end

    // reference model: what every bin should hold, plus counters
    logic [31:0] model [64];
    logic [31:0] model_cnt;
    logic        model_sat;

    int total = 0;
    int bad = 0;
    int n_done, last_done_cyc, n_acc;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (clear_done) begin
                n_done++;
                last_done_cyc = cyc;
            end
            if (in_valid && in_ready) n_acc++;
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) model[i] = '0;
        model_cnt = '0;
        model_sat = 1'b0;
    endtask

    function automatic int sweep_errs(input int start);
        int e = 0;
        if (wlog.size() < start + 64) return 64;
        for (int i = 0; i < 64; i++)
            if (wlog[start+i].addr != i || wlog[start+i].data !== 32'd0 ||
                wlog[start+i].cyc != wlog[start].cyc + i) e++;
        return e;
    endfunction

    function automatic int mem_errs();
        int e = 0;
        for (int i = 0; i < 64; i++)
            if (mem[i] !== model[i]) e++;
        return e;
    endfunction

    function automatic int done_expect(input int idx);
        return (wlog.size() > idx) ? wlog[idx].cyc + 1 : -1;
    endfunction

    initial begin
        int          sb [3];
        logic [5:0]  seq;
        int          k, rdy_errs, accepted, gap;
        logic        prev_acc, exp_ready, found;

        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        model_clear();
        reset = 1'b1; in_valid = 1'b0; in_bin = '0; clear_req = 1'b0;
        repeat (3) tick();

        // reset values, with a sample offered to prove in_ready is masked
        in_valid = 1'b1; in_bin = 6'd4;
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_clear_done", clear_done, 0);
        check("rst_sample_count", sample_count, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_chipselect", ram_chipselect, 0);
        check("rst_write", ram_write, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        tick();
        check("idle_in_ready", in_ready, 1);

        // full clear sweep after reset
        wlog.delete(); n_done = 0; n_acc = 0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        run(70);
        model_clear();
        check("clr_done_pulses", n_done, 1);
        check("clr_write_count", wlog.size(), 64);
        check("clr_sweep_errs", sweep_errs(0), 0);
        check("clr_done_cycle", last_done_cyc, done_expect(63));
        check("clr_sample_count", sample_count, 0);
        check("clr_busy", busy, 0);
        check("clr_mem", mem_errs(), 0);

        // samples 5, 5, 9 with in_valid held
        sb = '{5, 5, 9};
        seq = '0; k = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (k < 3);
            in_bin = (k < 3) ? 6'(sb[k]) : 6'd0;
            #1;
            seq = {seq[4:0], in_ready};
            if (in_valid && in_ready) k++;
            tick();
        end
        in_valid = 1'b0;
        model[5] = 32'd2; model[9] = 32'd1; model_cnt = 32'd3;
        check("seq_in_ready", seq, 6'b101010);
        check("seq_bin5", mem[5], 2);
        check("seq_bin9", mem[9], 1);
        check("seq_sample_count", sample_count, 3);

        // random samples with random gaps
        prev_acc = 1'b0; rdy_errs = 0; accepted = 0;
        for (int s = 0; s < 400 && accepted < 60; s++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_bin = 6'($urandom_range(0, 63));
            #1;
            exp_ready = !prev_acc;
            if (in_ready !== exp_ready) rdy_errs++;
            prev_acc = in_valid && exp_ready;
            if (prev_acc) begin
                model[in_bin] = model[in_bin] + 32'd1;
                model_cnt = model_cnt + 32'd1;
                accepted++;
            end
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("rnd_ready_errs", rdy_errs, 0);
        check("rnd_accepted", accepted, 60);
        check("rnd_sample_count", sample_count, model_cnt);
        check("rnd_mem", mem_errs(), 0);

        // bin at all-ones
        mem[3] = 32'hFFFF_FFFF; model[3] = 32'hFFFF_FFFF;
        in_valid = 1'b1; in_bin = 6'd3;
        #1;
        check("sat_in_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        tick();
`ifdef HIST_SATURATE_EN
        model_sat = 1'b1;
`else
        model[3] = 32'd0;
`endif
        model_cnt = model_cnt + 32'd1;
        check("sat_bin3", mem[3], model[3]);
        check("sat_flag", sat_flag, model_sat);
        check("sat_sample_count", sample_count, model_cnt);

        // clear requested during the UPD of bin 7; bin 2 offered throughout
        in_valid = 1'b1; in_bin = 6'd7;
        #1;
        check("c35_in_ready", in_ready, 1);
        tick();
        wlog.delete(); n_done = 0; n_acc = 0; found = 1'b0;
        clear_req = 1'b1; in_bin = 6'd2;
        tick();
        clear_req = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (clear_done) begin
                found = 1'b1;
                in_valid = 1'b0;
            end else begin
                #1;
                if (in_valid && in_ready) n_acc++;
                tick();
            end
        end
        in_valid = 1'b0;
        check("c35_done_seen", found, 1);
        check("c35_no_accept", n_acc, 0);
        check("c35_bin7_addr", (wlog.size() > 0) ? wlog[0].addr : -1, 7);
        check("c35_bin7_data", (wlog.size() > 0) ? wlog[0].data : 32'hX, model[7] + 32'd1);
        check("c35_sweep_errs", sweep_errs(1), 0);
        gap = (wlog.size() > 1) ? wlog[1].cyc - wlog[0].cyc : 0;
        check("c35_clr_start", (gap >= 1 && gap <= 2), 1);
        model_clear();
        tick();
        check("c35_sample_count", sample_count, 0);
        check("c35_sat_flag", sat_flag, model_sat);
        check("c35_mem", mem_errs(), 0);

        // clear and sample in the same cycle, then a clear re-requested mid-sweep
        wlog.delete(); n_done = 0; n_acc = 0; found = 1'b0;
        clear_req = 1'b1; in_valid = 1'b1; in_bin = 6'd1;
        #1;
        check("c38_in_ready", in_ready, 0);
        tick();
        clear_req = 1'b0; in_valid = 1'b0;
        check("c38_busy", busy, 1);
        for (int c = 0; c < 200 && n_done < 2; c++) begin
            if (!found && ram_write && ram_address == 6'd10) begin
                found = 1'b1;
                clear_req = 1'b1;
            end
            if (clear_done) n_done++;
            tick();
            clear_req = 1'b0;
        end
        check("c38_pending_seen", found, 1);
        check("c38_done_pulses", n_done, 2);
        check("c38_write_count", wlog.size(), 128);
        check("c38_sweep1", sweep_errs(0), 0);
        check("c38_sweep2", sweep_errs(64), 0);
        check("c38_sample_count", sample_count, 0);
        run(2);

        // reset in the middle of a sweep, then a complete sweep
        wlog.delete(); found = 1'b0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        for (int c = 0; c < 80 && !found; c++) begin
            if (ram_write && ram_address == 6'd20) begin
                found = 1'b1;
                reset = 1'b1;
            end else begin
                tick();
            end
        end
        check("c37_addr20_seen", found, 1);
        tick();
        check("c37_rst_busy", busy, 0);
        check("c37_rst_done", clear_done, 0);
        reset = 1'b0;
        n_done = 0;
        tick();
        check("c37_idle_busy", busy, 0);
        check("c37_idle_ready", in_ready, 1);
        run(10);
        check("c37_no_done", n_done, 0);
        wlog.delete(); n_done = 0;
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        run(70);
        model_clear();
        check("c37_done_pulses", n_done, 1);
        check("c37_write_count", wlog.size(), 64);
        check("c37_sweep_errs", sweep_errs(0), 0);
        check("c37_done_cycle", last_done_cyc, done_expect(63));
        check("c37_mem", mem_errs(), 0);

        // idle RAM port is quiet
        check("idle_chipselect", ram_chipselect, 0);
        check("idle_write", ram_write, 0);
        check("idle_writedata", ram_writedata, 0);
        check("byteenable_errs", be_errs, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hist_update_ctrl.md
HIST_UPDATE_CTRL -- requirements
Module: hist_update_ctrl

Interface
REQ-001 SHALL have parameter BIN_AW, default 6, meaning bin address width (64 bins).
REQ-002 SHALL have parameter CNT_W, default 32, meaning bin counter width and RAM word width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is clocked on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: a sample bin index is offered.
REQ-006 SHALL have port in_bin, input, BIN_AW bits: bin index to increment.
REQ-007 SHALL have port in_ready, output, 1 bit: the controller accepts a sample this cycle.
REQ-008 SHALL have port clear_req, input, 1 bit: single-cycle pulse requesting that all bins be zeroed.
REQ-009 SHALL have port clear_done, output, 1 bit: one-cycle pulse when a clear sweep completes.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 SHALL have port sample_count, output, CNT_W bits: number of samples accepted since the last reset or clear.
REQ-012 SHALL have port sat_flag, output, 1 bit: sticky flag, set when any bin saturates.
REQ-013 SHALL have ports ram_address (out, BIN_AW), ram_chipselect (out, 1), ram_write (out, 1), ram_byteenable (out, 4), ram_writedata (out, CNT_W) and ram_readdata (in, CNT_W): the RAM port, which has a registered address and unregistered output data.

Function
REQ-014 SHALL implement an FSM with states IDLE, UPD and CLR; the reset state is IDLE.
REQ-015 SHALL drive in_ready = 1 only in IDLE with no clear pending.
REQ-016 On an accept cycle (in_valid & in_ready), SHALL:
- drive ram_address = in_bin, ram_chipselect = 1, ram_write = 0;
- register in_bin;
- go to UPD.
REQ-017 In UPD, SHALL:
- write ram_readdata + 1 to the registered bin, with chipselect = 1, write = 1, byteenable = 4'hF;
- increment sample_count;
- return to IDLE.
REQ-018 Throughput SHALL be one sample per 2 cycles; a read in IDLE after a UPD write to the same bin SHALL observe the updated count, with no forwarding needed.
REQ-019 The increment SHALL be modulo 2^CNT_W unless HIST_SATURATE_EN is defined (REQ-031).
REQ-020 A clear_req received in UPD or CLR SHALL be latched as pending and serviced on the next IDLE cycle; a clear_req during CLR SHALL NOT restart the sweep.
REQ-021 When clear_req (or a pending clear) and in_valid coincide in IDLE, clear SHALL win; the sample is not accepted and in_ready = 0.
REQ-022 On entering CLR, SHALL zero sample_count and sat_flag and clear the pending flag.
REQ-023 In CLR, SHALL write 0 to addresses 0, 1, ... 2^BIN_AW-1, one per cycle, with chipselect = 1, write = 1, byteenable = 4'hF.
REQ-024 After writing the last address, SHALL pulse clear_done for exactly one cycle (the cycle after the last write) and return to IDLE.
REQ-025 Outside the states above, SHALL drive ram_chipselect = 0, ram_write = 0 and ram_writedata = 0.
REQ-026 sample_count SHALL wrap at 2^CNT_W, with no flag.

Reset
REQ-027 While reset = 1, SHALL force: state IDLE, in_ready = 0, busy = 0, clear_done = 0, sample_count = 0, sat_flag = 0, clear pending = 0, ram_chipselect = 0, ram_write = 0.
REQ-028 Reset during UPD or CLR SHALL abort the operation without emitting clear_done; RAM contents are then undefined until a clear.
REQ-029 RAM contents SHALL NOT be cleared by reset; software issues clear_req after reset.

Configuration
REQ-030 The macro HIST_SATURATE_EN SHALL select the counting behaviour.
REQ-031 With HIST_SATURATE_EN defined:
- a bin at all-ones SHALL be rewritten unchanged;
- sat_flag SHALL be set the same cycle, and stays set until reset or clear.
REQ-032 Without HIST_SATURATE_EN, bins SHALL wrap to 0 and sat_flag SHALL be tied to 0.

Verification
REQ-033 Reset, then clear_req -> 64 consecutive writes of 0 to addresses 0..63, clear_done pulses once in the cycle after the write to address 63, and sample_count = 0.
REQ-034 After a clear, samples 5, 5, 9 with in_valid held -> bin5 = 2, bin9 = 1, sample_count = 3, in_ready toggling 1,0,1,0,...
REQ-035 clear_req asserted during UPD for bin 7 -> bin 7's write completes, CLR starts the next cycle, and no sample is accepted until clear_done.
REQ-036 Preload bin 3 = 32'hFFFFFFFF, then send sample 3 -> with macro: bin3 = FFFFFFFF and sat_flag = 1; without macro: bin3 = 0 and sat_flag = 0.
REQ-037 Assert reset at sweep address 20 -> no clear_done, IDLE next cycle; a new clear_req then completes the full 64-address sweep.
REQ-038 clear_req and in_valid (bin 1) in the same IDLE cycle -> in_ready = 0, CLR entered, bin 1 not incremented.
